// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the halt FSM encoding and the fixed front-end stage indices.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_e;

    localparam int STAGE_F = 0;
    localparam int STAGE_D = 1;

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-writeback scoreboard for long-latency operations.
// One bit per register; register 0 never reports a match.
module hazard_scoreboard
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_idx,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_idx,
    input  logic [REG_AW-1:0] rs1_idx,
    input  logic [REG_AW-1:0] rs2_idx,
    input  logic [REG_AW-1:0] rd_idx,
    output logic              rs1_hit,
    output logic              rs2_hit,
    output logic              rd_hit,
    output logic              empty
);

    logic [NUM_REGS-1:0] pend;

    // Clear first, then set, so a same-register set overrides the clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend <= '0;
        end else begin
            if (clr_en) pend[clr_idx] <= 1'b0;
            if (set_en) pend[set_idx] <= 1'b1;
        end
    end

    assign rs1_hit = (rs1_idx != '0) && pend[rs1_idx];
    assign rs2_hit = (rs2_idx != '0) && pend[rs2_idx];
    assign rd_hit  = (rd_idx  != '0) && pend[rd_idx];
    assign empty   = ~|pend;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush generator for an N-stage in-order pipeline with scoreboard,
// halt/drain/resume FSM and a sticky busy watchdog.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int NUM_STAGES   = 5,
    parameter int EXEC_IDX     = 2,
    parameter int NUM_REGS     = 32,
    parameter int REG_AW       = 5,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  halt_req_i,
    input  logic                  resume_i,
    input  logic [REG_AW-1:0]     D_rs1_i,
    input  logic [REG_AW-1:0]     D_rs2_i,
    input  logic                  D_rs1Used_i,
    input  logic                  D_rs2Used_i,
    input  logic [REG_AW-1:0]     D_rd_i,
    input  logic                  D_rdUsed_i,
    input  logic [REG_AW-1:0]     E_rd_i,
    input  logic                  E_isLoad_i,
    input  logic                  E_longIssue_i,
    input  logic                  E_wen_i,
    input  logic                  W_longDone_i,
    input  logic [REG_AW-1:0]     W_longRd_i,
    input  logic                  aluBusy_i,
    input  logic                  E_correctPC_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  dataHazard_o,
    output logic                  halted_o,
    output logic                  watchdog_o
);

    localparam int DCW = $clog2(NUM_STAGES + 1);
    localparam int BCW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(NUM_STAGES - EXEC_IDX);
    localparam logic [BCW-1:0] BUSY_MAX   = BCW'(BUSY_TIMEOUT);
    localparam logic [BCW-1:0] BUSY_LAST  = BCW'(BUSY_TIMEOUT - 1);

    hz_state_e      state;
    hz_state_e      state_nxt;
    logic [DCW-1:0] drain_cnt;
    logic [BCW-1:0] busy_cnt;
    logic           rs1_hit;
    logic           rs2_hit;
    logic           rd_hit;
    logic           sb_empty;
    logic           e_pending;
    logic           not_run;
    logic           sb_set;

    assign sb_set = E_longIssue_i & E_wen_i & (E_rd_i != '0)
                  & ~stall_o[EXEC_IDX];

    hazard_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW)
    ) u_sb (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .set_en   (sb_set),
        .set_idx  (E_rd_i),
        .clr_en   (W_longDone_i),
        .clr_idx  (W_longRd_i),
        .rs1_idx  (D_rs1_i),
        .rs2_idx  (D_rs2_i),
        .rd_idx   (D_rd_i),
        .rs1_hit  (rs1_hit),
        .rs2_hit  (rs2_hit),
        .rd_hit   (rd_hit),
        .empty    (sb_empty)
    );

    // Execute holds a load or long op whose result decode cannot see yet.
    assign e_pending = E_wen_i & (E_isLoad_i | E_longIssue_i)
                     & (E_rd_i != '0);

    // Decode hazard: pending scoreboard bit, in-flight E result, or WAW.
    always_comb begin
        dataHazard_o =
            (D_rs1Used_i & (rs1_hit | (e_pending & (D_rs1_i == E_rd_i))))
          | (D_rs2Used_i & (rs2_hit | (e_pending & (D_rs2_i == E_rd_i))))
          | (D_rdUsed_i  & (rd_hit  | (e_pending & (D_rd_i  == E_rd_i))));
    end

    assign not_run = (state != ST_RUN);

    // Per-stage stall/flush vectors; both forced low while in reset.
    always_comb begin
        stall_o = '0;
        flush_o = '0;
        if (rst_n_i) begin
            for (int k = 0; k <= EXEC_IDX; k++) begin
                stall_o[k] = aluBusy_i;
            end
            stall_o[STAGE_F] = stall_o[STAGE_F] | dataHazard_o | not_run;
            stall_o[STAGE_D] = stall_o[STAGE_D] | dataHazard_o | not_run;
            flush_o[STAGE_D]    = E_correctPC_i;
            flush_o[EXEC_IDX]   = E_correctPC_i | dataHazard_o | not_run;
            flush_o[EXEC_IDX+1] = aluBusy_i;
        end
    end

    // Halt FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= ST_RUN;
        else          state <= state_nxt;
    end

    // Halt FSM next-state: drain must finish and scoreboard empty out.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN:    if (halt_req_i) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (drain_cnt == '0 && sb_empty) state_nxt = ST_HALTED;
            ST_HALTED: if (resume_i && !halt_req_i) state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    // Halt FSM outputs.
    always_comb begin
        halted_o = (state == ST_HALTED);
    end

    // Drain counter: loaded on halt entry, counts down on non-busy cycles.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drain_cnt <= '0;
        end else if (state == ST_RUN && halt_req_i) begin
            drain_cnt <= DRAIN_LOAD;
        end else if (state == ST_DRAIN && !aluBusy_i && drain_cnt != '0) begin
            drain_cnt <= drain_cnt - DCW'(1);
        end
    end

    // Busy watchdog: saturating run-length counter with sticky error flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_cnt   <= '0;
            watchdog_o <= 1'b0;
        end else if (aluBusy_i) begin
            if (busy_cnt != BUSY_MAX) busy_cnt <= busy_cnt + BCW'(1);
            if (busy_cnt >= BUSY_LAST) watchdog_o <= 1'b1;
        end else begin
            busy_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl (two configurations)
// against a behavioural model of stall/flush, scoreboard, FSM and watchdog.
module tb_pipeline_hazard_ctrl;

    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic halt_req, resume;
    logic [4:0] d_rs1, d_rs2, d_rd, e_rd, w_rd;
    logic d_rs1u, d_rs2u, d_rdu, e_ld, e_long, e_wen, w_done, busy, cpc;
    logic [4:0] stall0, flush0;
    logic [6:0] stall1, flush1;
    logic haz0, haz1, hlt0, hlt1, wd0, wd1;

    int n_tot = 0;
    int n_pass = 0;

    bit sb[32];
    int mode[2];
    int dcnt[2];
    int blen;
    bit wd;
    int ns_a[2] = '{5, 7};
    int ex_a[2] = '{2, 3};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut0 (
        .clk_i(clk), .rst_n_i(rst_n),
        .halt_req_i(halt_req), .resume_i(resume),
        .D_rs1_i(d_rs1), .D_rs2_i(d_rs2),
        .D_rs1Used_i(d_rs1u), .D_rs2Used_i(d_rs2u),
        .D_rd_i(d_rd), .D_rdUsed_i(d_rdu),
        .E_rd_i(e_rd), .E_isLoad_i(e_ld), .E_longIssue_i(e_long),
        .E_wen_i(e_wen), .W_longDone_i(w_done), .W_longRd_i(w_rd),
        .aluBusy_i(busy), .E_correctPC_i(cpc),
        .stall_o(stall0), .flush_o(flush0), .dataHazard_o(haz0),
        .halted_o(hlt0), .watchdog_o(wd0)
    );

    pipeline_hazard_ctrl #(.NUM_STAGES(7), .EXEC_IDX(3)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n),
        .halt_req_i(halt_req), .resume_i(resume),
        .D_rs1_i(d_rs1), .D_rs2_i(d_rs2),
        .D_rs1Used_i(d_rs1u), .D_rs2Used_i(d_rs2u),
        .D_rd_i(d_rd), .D_rdUsed_i(d_rdu),
        .E_rd_i(e_rd), .E_isLoad_i(e_ld), .E_longIssue_i(e_long),
        .E_wen_i(e_wen), .W_longDone_i(w_done), .W_longRd_i(w_rd),
        .aluBusy_i(busy), .E_correctPC_i(cpc),
        .stall_o(stall1), .flush_o(flush1), .dataHazard_o(haz1),
        .halted_o(hlt1), .watchdog_o(wd1)
    );

    task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
    endtask

    function automatic bit src_haz(logic [4:0] r, logic u);
        bit eb;
        eb = e_wen && (e_ld || e_long) && (e_rd != 0);
        return u && (r != 0) && (sb[r] || (eb && r == e_rd));
    endfunction

    function automatic bit m_haz();
        return src_haz(d_rs1, d_rs1u) || src_haz(d_rs2, d_rs2u)
            || src_haz(d_rd, d_rdu);
    endfunction

    function automatic logic [7:0] m_stall(int i);
        logic [7:0] v;
        v = '0;
        if (!rst_n) return v;
        for (int k = 0; k < ns_a[i]; k++)
            v[k] = (k <= ex_a[i] && busy)
                || (k <= 1 && (m_haz() || mode[i] != 0));
        return v;
    endfunction

    function automatic logic [7:0] m_flush(int i);
        logic [7:0] v;
        v = '0;
        if (!rst_n) return v;
        v[1] = cpc;
        v[ex_a[i]] = cpc || m_haz() || mode[i] != 0;
        v[ex_a[i] + 1] = busy;
        return v;
    endfunction

    task automatic model_reset();
        foreach (sb[r]) sb[r] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mode[i] = 0;
            dcnt[i] = 0;
        end
        blen = 0;
        wd = 1'b0;
    endtask

    task automatic model_step();
        bit empty;
        bit set;
        if (!rst_n) begin
            model_reset();
            return;
        end
        empty = 1'b1;
        foreach (sb[r]) if (sb[r]) empty = 1'b0;
        for (int i = 0; i < 2; i++) begin
            case (mode[i])
                0: if (halt_req) begin
                    mode[i] = 1;
                    dcnt[i] = ns_a[i] - ex_a[i];
                end
                1: if (dcnt[i] == 0 && empty) mode[i] = 2;
                   else if (!busy && dcnt[i] > 0) dcnt[i]--;
                default: if (resume && !halt_req) mode[i] = 0;
            endcase
        end
        set = e_long && e_wen && (e_rd != 0) && !busy;
        if (w_done) sb[w_rd] = 1'b0;
        if (set) sb[e_rd] = 1'b1;
        blen = busy ? ((blen < TO) ? blen + 1 : TO) : 0;
        if (blen >= TO) wd = 1'b1;
    endtask

    task automatic check_all();
        if (!rst_n) model_reset();
        chk("haz0", 8'(haz0), 8'(m_haz()));
        chk("haz1", 8'(haz1), 8'(m_haz()));
        chk("stall0", 8'(stall0), m_stall(0));
        chk("stall1", 8'(stall1), m_stall(1));
        chk("flush0", 8'(flush0), m_flush(0));
        chk("flush1", 8'(flush1), m_flush(1));
        chk("halted0", 8'(hlt0), 8'(mode[0] == 2));
        chk("halted1", 8'(hlt1), 8'(mode[1] == 2));
        chk("wdog0", 8'(wd0), 8'(wd));
        chk("wdog1", 8'(wd1), 8'(wd));
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        halt_req = 0; resume = 0;
        d_rs1 = 0; d_rs2 = 0; d_rd = 0; e_rd = 0; w_rd = 0;
        d_rs1u = 0; d_rs2u = 0; d_rdu = 0;
        e_ld = 0; e_long = 0; e_wen = 0; w_done = 0;
        busy = 0; cpc = 0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        busy = 1'b1;
        #2;
        chk("rst_stall0", 8'(stall0), 8'h00);
        chk("rst_flush0", 8'(flush0), 8'h00);
        chk("rst_halt0", 8'(hlt0), 8'h00);
        chk("rst_wdog0", 8'(wd0), 8'h00);
        step();
        step();
        rst_n = 1'b1;
        busy = 1'b0;
        step();

        // load-use
        e_ld = 1; e_wen = 1; e_rd = 5; d_rs1 = 5; d_rs1u = 1;
        #2;
        chk("lu_haz", 8'(haz0), 8'h01);
        chk("lu_stall0", 8'(stall0), 8'b00011);
        chk("lu_flush0", 8'(flush0), 8'b00100);
        chk("lu_flush1", 8'(flush1), 8'b0001000);
        step();
        e_rd = 0; d_rs1 = 0;
        #2;
        chk("lu_r0", 8'(haz0), 8'h00);
        step();

        // long op on x7
        idle();
        e_long = 1; e_wen = 1; e_rd = 7; d_rs2 = 7; d_rs2u = 1;
        step();
        e_long = 0; e_wen = 0; e_rd = 0;
        #2;
        chk("long_sb", 8'(haz0), 8'h01);
        step();
        step();
        w_done = 1; w_rd = 7;
        step();
        w_done = 0;
        #2;
        chk("long_clr", 8'(haz0), 8'h00);
        step();

        // same-cycle set + clear on x9
        idle();
        e_long = 1; e_wen = 1; e_rd = 9; w_done = 1; w_rd = 9;
        step();
        idle();
        d_rs1 = 9; d_rs1u = 1;
        #2;
        chk("setclr9", 8'(haz0), 8'h01);
        step();

        // busy + redirect
        idle();
        busy = 1; cpc = 1;
        #2;
        chk("bc_stall0", 8'(stall0), 8'b00111);
        chk("bc_flush0", 8'(flush0), 8'b01110);
        step();

        // halt with x9 pending
        idle();
        halt_req = 1;
        step();
        halt_req = 0;
        for (int i = 0; i < 6; i++) step();
        #2;
        chk("drain_halt", 8'(hlt0), 8'h00);
        chk("drain_stall", 8'(stall0), 8'b00011);
        w_done = 1; w_rd = 9;
        step();
        w_done = 0;
        #2;
        chk("drain_wait", 8'(hlt0), 8'h00);
        step();
        #2;
        chk("halted0", 8'(hlt0), 8'h01);
        chk("halted1", 8'(hlt1), 8'h01);
        halt_req = 1; resume = 1;
        step();
        halt_req = 0;
        #2;
        chk("both_hi", 8'(hlt0), 8'h01);
        step();
        resume = 0;
        #2;
        chk("resumed", 8'(hlt0), 8'h00);
        chk("res_stall", 8'(stall0), 8'h00);
        step();

        // watchdog
        idle();
        busy = 1;
        for (int i = 0; i < TO - 1; i++) step();
        busy = 0;
        #2;
        chk("wd_63", 8'(wd0), 8'h00);
        step();
        busy = 1;
        for (int i = 0; i < TO; i++) step();
        busy = 0;
        #2;
        chk("wd_64", 8'(wd0), 8'h01);
        step();
        step();
        chk("wd_stick", 8'(wd1), 8'h01);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            halt_req = ($urandom_range(0, 15) == 0);
            resume = ($urandom_range(0, 3) == 0);
            d_rs1 = 5'($urandom_range(0, 7));
            d_rs2 = 5'($urandom_range(0, 7));
            d_rd = 5'($urandom_range(0, 7));
            e_rd = 5'($urandom_range(0, 7));
            w_rd = 5'($urandom_range(0, 7));
            d_rs1u = 1'($urandom);
            d_rs2u = 1'($urandom);
            d_rdu = 1'($urandom);
            e_ld = ($urandom_range(0, 3) == 0);
            e_long = ($urandom_range(0, 4) == 0);
            e_wen = 1'($urandom);
            w_done = ($urandom_range(0, 2) == 0);
            busy = ($urandom_range(0, 5) == 0);
            cpc = ($urandom_range(0, 7) == 0);
            step();
        end

        // reset while draining with a pending bit
        idle();
        rst_n = 1;
        step();
        e_long = 1; e_wen = 1; e_rd = 12;
        step();
        idle();
        halt_req = 1;
        step();
        halt_req = 0;
        step();
        rst_n = 0;
        busy = 1;
        #2;
        chk("mr_stall0", 8'(stall0), 8'h00);
        chk("mr_stall1", 8'(stall1), 8'h00);
        chk("mr_flush1", 8'(flush1), 8'h00);
        chk("mr_halt1", 8'(hlt1), 8'h00);
        step();
        rst_n = 1;
        busy = 0;
        d_rs1 = 12; d_rs1u = 1;
        #2;
        chk("mr_sb0", 8'(haz0), 8'h00);
        chk("mr_sb1", 8'(haz1), 8'h00);
        step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Parametrised successor to the fixed 5-stage stall/flush controller.
- Generates per-stage stall and flush vectors for an N-stage in-order core.
- Adds a register scoreboard for long-latency ops, load-use/WAW hazard detection, a halt/drain/resume FSM and a busy watchdog.
- Sits beside the pipeline registers; all pipeline register enables and bubble inserts come from here.

Parameters:
NUM_STAGES, 5, pipeline stages; index 0=F, 1=D, EXEC_IDX=E, the rest are later stages (min 4)
EXEC_IDX, 2, index of the execute stage (must be 2..NUM_STAGES-2)
NUM_REGS, 32, architectural registers tracked by the scoreboard
REG_AW, 5, register index width (clog2 NUM_REGS)
BUSY_TIMEOUT, 64, max consecutive aluBusy cycles before the watchdog fires

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
halt_req_i  in  1  request halt (sampled level; latched)
resume_i  in  1  leave HALTED
D_rs1_i, D_rs2_i  in  REG_AW  decode source registers
D_rs1Used_i, D_rs2Used_i  in  1  source actually read
D_rd_i  in  REG_AW  decode destination
D_rdUsed_i  in  1  decode writes rd
E_rd_i  in  REG_AW  execute destination
E_isLoad_i  in  1  execute instruction is a load
E_longIssue_i  in  1  execute instruction is multi-cycle with writeback via W_longDone
E_wen_i  in  1  execute instruction writes rd
W_longDone_i  in  1  long op completes
W_longRd_i  in  REG_AW  completing register
aluBusy_i  in  1  execute unit busy
E_correctPC_i  in  1  execute redirects PC
stall_o  out  NUM_STAGES  stage k holds its register
flush_o  out  NUM_STAGES  stage k input register loads a bubble
dataHazard_o  out  1  decode hazard this cycle
halted_o  out  1  FSM in HALTED
watchdog_o  out  1  sticky busy-timeout error

Behaviour:
- Reset (async, rst_n_i=0):
  - scoreboard cleared, FSM=RUN, busy counter=0, drain counter=0, watchdog_o=0.
  - stall_o=0, flush_o=0 while in reset.
- dataHazard (combinational), asserted when any of these holds; register 0 never hazards:
  - a used rs matches a set scoreboard bit;
  - a used rs or a used rd matches E_rd with E_wen & (E_isLoad | E_longIssue);
  - D_rdUsed and the scoreboard bit for D_rd is set (WAW).
- Stall and flush equations:
  - stall_o[k] = 1 for k<=EXEC_IDX when aluBusy.
  - stall_o[k] = 1 for k<=1 when dataHazard or FSM!=RUN.
  - Stages above EXEC_IDX never stall.
  - flush_o[EXEC_IDX+1] = aluBusy.
  - flush_o[1] = E_correctPC. flush_o[EXEC_IDX] = E_correctPC | dataHazard | (FSM!=RUN).
  - Other flush bits are 0.
  - stall and flush of the same stage: flush wins (output both; the pipeline register gives flush priority).
- Scoreboard update, registered:
  - set bit E_rd when E_longIssue & E_wen & E_rd!=0 & !stall_o[EXEC_IDX];
  - clear bit W_longRd when W_longDone;
  - set and clear on the same register in the same cycle: set wins;
  - clear of an already-clear bit is a no-op.
- FSM:
  - RUN: if halt_req_i -> DRAIN; drain counter loaded with NUM_STAGES-EXEC_IDX.
  - DRAIN: the counter decrements each cycle with !aluBusy. When counter==0 and scoreboard empty -> HALTED. halt_req_i deasserting here does not abort the drain.
  - HALTED: halted_o=1. resume_i -> RUN next cycle. halt_req_i and resume_i both high: stay HALTED.
  - E_correctPC during DRAIN still flushes normally.
- Watchdog:
  - busy counter increments while aluBusy and clears when it drops; it saturates.
  - Reaching BUSY_TIMEOUT sets watchdog_o, which stays set until reset.
  - The watchdog does not alter stall/flush.
- Latency: stall/flush/dataHazard are same-cycle combinational; scoreboard, FSM and watchdog effects appear from the next cycle.
- Mid-operation reset clears everything immediately, including pending scoreboard bits.

Decomposition:
- Shared package: FSM state typedef (RUN, DRAIN, HALTED) and stage index constants (STAGE_F=0, STAGE_D=1).
- One sub-module, hazard_scoreboard: NUM_REGS bitvector with set/clear ports, two read-match outputs, a WAW match output and an empty flag.
- The top level keeps the FSM, watchdog and vector generation.

Test Plan:
- Load-use: E_isLoad=1, E_wen=1, E_rd=5; D_rs1=5 used -> dataHazard_o=1, stall_o=5'b00011, flush_o[2]=1. With E_rd=0 -> no hazard.
- Long op: E_longIssue with rd=7, not stalled -> bit 7 set next cycle. D_rs2=7 stalls until W_longDone rd=7. The cycle after that, dataHazard_o=0. Same-cycle set+clear on rd=9 -> bit stays set.
- aluBusy=1 with E_correctPC=1 -> stall_o=5'b00111; flush_o=5'b01110, with flush beating stall on bits 1 and 2.
- Halt: halt_req pulse while a scoreboard bit is pending -> DRAIN persists until W_longDone, then HALTED after the drain count. resume_i -> RUN the following cycle, with stall_o=0.
- Watchdog: hold aluBusy for BUSY_TIMEOUT cycles -> watchdog_o=1 and stays 1 after busy drops. A 63-cycle burst at the default parameter does not fire it.
- Reset in DRAIN with bits pending -> halted_o=0, scoreboard empty, stall_o=0 immediately; check also with NUM_STAGES=7, EXEC_IDX=3.
